// File: rtl/frame_buf_pkg.sv
// Shared definitions for the RGB frame buffer sequencer: FSM state encoding,
// default buffer geometry and the memory rw encoding.
package frame_buf_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CLR_ISSUE = 4'd1,
        ST_CLR_WAIT  = 4'd2,
        ST_CAP_ISSUE = 4'd3,
        ST_CAP_WAIT  = 4'd4,
        ST_RD_READY  = 4'd5,
        ST_RD_ISSUE  = 4'd6,
        ST_RD_WAIT   = 4'd7,
        ST_DONE      = 4'd8,
        ST_DRAIN     = 4'd9,
        ST_ERROR     = 4'd10
    } fbState_t;

    localparam int DEF_N       = 2;
    localparam int DEF_M       = 2;
    localparam int FRAME_BYTES = 3 * DEF_N * DEF_M;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// Control/status bundle between the frame sequencer (master) and the
// camera, grayscaler and R/W memory it coordinates (slave).
interface frame_buffer_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             frame_start;
    logic             clear_en;
    logic             gray_ready;
    logic             gray_pause;
    logic             abort;
    logic             rwm_done;
    logic             rwm_enable;
    logic             rwm_rw;
    logic             rwm_clear;
    logic             cam_capture;
    logic             gray_start;
    logic             busy;
    logic             frame_done;
    logic             error;
    logic [CNT_W-1:0] frame_count;

    modport master (
        input  frame_start, clear_en, gray_ready, gray_pause, abort, rwm_done,
        output rwm_enable, rwm_rw, rwm_clear, cam_capture, gray_start,
               busy, frame_done, error, frame_count
    );

    modport slave (
        output frame_start, clear_en, gray_ready, gray_pause, abort, rwm_done,
        input  rwm_enable, rwm_rw, rwm_clear, cam_capture, gray_start,
               busy, frame_done, error, frame_count
    );
endinterface

// File: rtl/fb_watchdog.sv
// Watchdog counter: clears, holds or advances; flags expiry on the cycle
// that would make the TIMEOUT-th counted cycle.
module fb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    input  logic i_hold,
    output logic o_expire
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count && !i_hold) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_count && !i_hold && !i_clear && (r_count == W'(TIMEOUT - 1));

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Frame sequencer: optional clear, camera capture, then readout to the
// grayscaler, with watchdog, abort/drain path and completed-frame counter.
module frame_buffer_ctrl
    import frame_buf_pkg::*;
#(
    parameter int N       = 2,
    parameter int M       = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    frame_buffer_ctrl_if.master bus
);

    fbState_t         r_state;
    fbState_t         w_next;
    logic             r_memIdle;
    logic             r_error;
    logic [CNT_W-1:0] r_frameCount;
    logic             w_issuing;
    logic             w_counting;
    logic             w_wdClear;
    logic             w_expire;

    assign w_issuing  = (r_state == ST_CLR_ISSUE) || (r_state == ST_CAP_ISSUE) ||
                        (r_state == ST_RD_ISSUE);
    assign w_counting = (r_state == ST_CLR_WAIT) || (r_state == ST_CAP_WAIT) ||
                        (r_state == ST_RD_WAIT)  || (r_state == ST_DRAIN);
    assign w_wdClear  = !w_counting || bus.rwm_done || bus.abort;

    fb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_wdClear),
        .i_count  (w_counting),
        .i_hold   (bus.gray_pause),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_memIdle    <= 1'b1;
            r_error      <= 1'b0;
            r_frameCount <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == ST_ERROR && bus.abort) begin
                r_memIdle <= 1'b1;
            end else if (w_issuing) begin
                r_memIdle <= 1'b0;
            end else if (bus.rwm_done) begin
                r_memIdle <= 1'b1;
            end

            if (w_next == ST_ERROR) begin
                r_error <= 1'b1;
            end else if (r_state == ST_IDLE && bus.frame_start && !bus.abort) begin
                r_error <= 1'b0;
            end

            if (r_state == ST_DONE && !bus.abort) begin
                r_frameCount <= r_frameCount + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    w_next = bus.clear_en ? ST_CLR_ISSUE : ST_CAP_ISSUE;
                end
            end
            ST_CLR_ISSUE: w_next = ST_CLR_WAIT;
            ST_CLR_WAIT: begin
                if (bus.rwm_done)  w_next = ST_CAP_ISSUE;
                else if (w_expire) w_next = ST_ERROR;
            end
            ST_CAP_ISSUE: w_next = ST_CAP_WAIT;
            ST_CAP_WAIT: begin
                if (bus.rwm_done)  w_next = ST_RD_READY;
                else if (w_expire) w_next = ST_ERROR;
            end
            ST_RD_READY: begin
                if (bus.gray_ready) w_next = ST_RD_ISSUE;
            end
            ST_RD_ISSUE: w_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (bus.rwm_done)  w_next = ST_DONE;
                else if (w_expire) w_next = ST_ERROR;
            end
            ST_DONE: w_next = ST_IDLE;
            ST_DRAIN: begin
                if (bus.rwm_done)  w_next = ST_IDLE;
                else if (w_expire) w_next = ST_ERROR;
            end
            ST_ERROR: w_next = ST_ERROR;
            default:  w_next = ST_IDLE;
        endcase

        // A command leaving in an ISSUE cycle already occupies the memory, so drain it.
        if (bus.abort) begin
            if (r_state == ST_ERROR) begin
                w_next = ST_IDLE;
            end else if (w_issuing) begin
                w_next = ST_DRAIN;
            end else if (r_memIdle || bus.rwm_done) begin
                w_next = ST_IDLE;
            end else begin
                w_next = ST_DRAIN;
            end
        end
    end

    assign bus.rwm_enable  = w_issuing;
    assign bus.rwm_rw      = ((r_state == ST_CAP_ISSUE) || (r_state == ST_CAP_WAIT)) ? RW_WRITE : RW_READ;
    assign bus.rwm_clear   = (r_state == ST_CLR_ISSUE) || (r_state == ST_CLR_WAIT);
    assign bus.cam_capture = (r_state == ST_CAP_ISSUE) || (r_state == ST_CAP_WAIT);
    assign bus.gray_start  = (r_state == ST_RD_ISSUE);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.frame_done  = (r_state == ST_DONE);
    assign bus.error       = r_error;
    assign bus.frame_count = r_frameCount;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl with a behavioural R/W memory that
// takes FRAME_BYTES cycles per operation (reads stall while gray_pause is high).
module tb_frame_buffer_ctrl;
    import frame_buf_pkg::*;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    frame_buffer_ctrl_if #(.CNT_W(8)) bus ();

    frame_buffer_ctrl #(
        .N       (2),
        .M       (2),
        .TIMEOUT (64),
        .CNT_W   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic memActive;
    logic memIsRead;
    logic memHang;
    int   memRem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memActive <= 1'b0;
            memIsRead <= 1'b0;
            memRem    <= 0;
        end else if (bus.rwm_enable) begin
            memActive <= 1'b1;
            memIsRead <= !bus.rwm_rw && !bus.rwm_clear;
            memRem    <= FRAME_BYTES;
        end else if (memActive && !memHang && !(memIsRead && bus.gray_pause)) begin
            if (memRem == 1) memActive <= 1'b0;
            memRem <= memRem - 1;
        end
    end

    assign bus.rwm_done = memActive && !memHang && (memRem == 1) && !(memIsRead && bus.gray_pause);

    int         enCount;
    int         widthViol;
    int         doneCount;
    logic       prevEn;
    logic [1:0] cmdLog[$];

    initial begin
        enCount   = 0;
        widthViol = 0;
        doneCount = 0;
        prevEn    = 1'b0;
    end

    always @(posedge clk) begin
        if (bus.rwm_enable) begin
            enCount++;
            cmdLog.push_back({bus.rwm_clear, bus.rwm_rw});
        end
        if (bus.rwm_enable && prevEn) widthViol++;
        prevEn = bus.rwm_enable;
        if (bus.frame_done) doneCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startFrame(input logic clr);
        bus.clear_en    = clr;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.clear_en    = 1'b0;
    endtask

    task automatic waitFrameDone(inout int cyc, output int fdCyc);
        fdCyc = -1;
        for (int k = 0; k < 400 && fdCyc < 0; k++) begin
            tick();
            cyc++;
            if (bus.frame_done) fdCyc = cyc;
        end
    endtask

    function automatic logic [1:0] logAt(input int idx);
        logic [1:0] v;
        v = 2'bxx;
        if (cmdLog.size() > idx) v = cmdLog[idx];
        return v;
    endfunction

    function automatic logic [7:0] outVec();
        return {bus.rwm_enable, bus.rwm_rw, bus.rwm_clear, bus.cam_capture,
                bus.gray_start, bus.busy, bus.frame_done, bus.error};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        compared++;
        if (outVec() !== 8'h00) begin
            $display("[TB] FAIL reset_outputs: got %b want 00000000", outVec());
            mismatched++;
        end
        compared++;
        if (bus.frame_count !== 8'd0) begin
            $display("[TB] FAIL reset_count: got %0d want 0", bus.frame_count);
            mismatched++;
        end
        rst_n = 1'b1;
        tick();
        compared++;
        if (bus.busy !== 1'b0) begin
            $display("[TB] FAIL reset_release_busy: got %b want 0", bus.busy);
            mismatched++;
        end
    endtask

    task automatic test_normal();
        int startEn, startLog, startDone, cyc, gsCyc, fdCyc;
        startEn   = enCount;
        startLog  = cmdLog.size();
        startDone = doneCount;
        gsCyc     = -1;
        fdCyc     = -1;
        bus.gray_ready = 1'b1;
        startFrame(1'b0);
        cyc = 1;
        compared++;
        if ({bus.rwm_enable, bus.rwm_rw, bus.cam_capture, bus.busy} !== 4'b1111) begin
            $display("[TB] FAIL normal_cap_issue: got %b want 1111",
                     {bus.rwm_enable, bus.rwm_rw, bus.cam_capture, bus.busy});
            mismatched++;
        end
        for (int k = 0; k < 200 && fdCyc < 0; k++) begin
            tick();
            cyc++;
            if (bus.gray_start && gsCyc < 0) gsCyc = cyc;
            if (bus.frame_done) fdCyc = cyc;
        end
        compared++;
        if (gsCyc !== 15) begin
            $display("[TB] FAIL normal_gray_start_cycle: got %0d want 15", gsCyc);
            mismatched++;
        end
        compared++;
        if (fdCyc !== 28) begin
            $display("[TB] FAIL normal_done_cycle: got %0d want 28", fdCyc);
            mismatched++;
        end
        tick();
        compared++;
        if ({bus.frame_done, bus.busy} !== 2'b00) begin
            $display("[TB] FAIL normal_after_done: got %b want 00", {bus.frame_done, bus.busy});
            mismatched++;
        end
        compared++;
        if (bus.frame_count !== 8'd1) begin
            $display("[TB] FAIL normal_count: got %0d want 1", bus.frame_count);
            mismatched++;
        end
        compared++;
        if ({logAt(startLog), logAt(startLog + 1)} !== 4'b0100 || enCount - startEn != 2) begin
            $display("[TB] FAIL normal_cmds: got n=%0d %b %b want n=2 01 00",
                     enCount - startEn, logAt(startLog), logAt(startLog + 1));
            mismatched++;
        end
        compared++;
        if (doneCount - startDone != 1) begin
            $display("[TB] FAIL normal_done_pulses: got %0d want 1", doneCount - startDone);
            mismatched++;
        end
    endtask

    task automatic test_clear();
        int startEn, startLog, cyc, fdCyc;
        startEn  = enCount;
        startLog = cmdLog.size();
        startFrame(1'b1);
        cyc = 1;
        compared++;
        if ({bus.rwm_enable, bus.rwm_clear, bus.rwm_rw} !== 3'b110) begin
            $display("[TB] FAIL clear_issue: got %b want 110",
                     {bus.rwm_enable, bus.rwm_clear, bus.rwm_rw});
            mismatched++;
        end
        waitFrameDone(cyc, fdCyc);
        compared++;
        if (fdCyc !== 41) begin
            $display("[TB] FAIL clear_done_cycle: got %0d want 41", fdCyc);
            mismatched++;
        end
        compared++;
        if (enCount - startEn != 3 ||
            {logAt(startLog), logAt(startLog + 1), logAt(startLog + 2)} !== 6'b10_01_00) begin
            $display("[TB] FAIL clear_cmds: got n=%0d %b %b %b want n=3 10 01 00", enCount - startEn,
                     logAt(startLog), logAt(startLog + 1), logAt(startLog + 2));
            mismatched++;
        end
        compared++;
        if (widthViol !== 0) begin
            $display("[TB] FAIL enable_width: got %0d wide pulses want 0", widthViol);
            mismatched++;
        end
        tick();
        compared++;
        if (bus.frame_count !== 8'd2) begin
            $display("[TB] FAIL clear_count: got %0d want 2", bus.frame_count);
            mismatched++;
        end
    endtask

    task automatic test_gray_flow();
        int startEn, cyc, fdCyc;
        logic sawGs;
        logic sawErr;
        startEn = enCount;
        sawGs   = 1'b0;
        sawErr  = 1'b0;
        bus.gray_ready = 1'b0;
        startFrame(1'b0);
        cyc = 1;
        while (cyc < 33) begin
            tick();
            cyc++;
            if (bus.gray_start) sawGs = 1'b1;
        end
        compared++;
        if (sawGs !== 1'b0 || enCount - startEn != 1 || bus.busy !== 1'b1) begin
            $display("[TB] FAIL gray_wait_ready: got gs=%b n=%0d busy=%b want 0 1 1",
                     sawGs, enCount - startEn, bus.busy);
            mismatched++;
        end
        bus.gray_ready = 1'b1;
        tick();
        cyc++;
        compared++;
        if ({bus.gray_start, bus.rwm_enable, bus.rwm_rw} !== 3'b110) begin
            $display("[TB] FAIL gray_read_issue: got %b want 110",
                     {bus.gray_start, bus.rwm_enable, bus.rwm_rw});
            mismatched++;
        end
        while (cyc < 39) begin
            tick();
            cyc++;
        end
        bus.gray_pause = 1'b1;
        while (cyc < 139) begin
            tick();
            cyc++;
            if (bus.error) sawErr = 1'b1;
        end
        bus.gray_pause = 1'b0;
        compared++;
        if (sawErr !== 1'b0 || bus.busy !== 1'b1) begin
            $display("[TB] FAIL gray_pause_hold: got err=%b busy=%b want 0 1", sawErr, bus.busy);
            mismatched++;
        end
        waitFrameDone(cyc, fdCyc);
        compared++;
        if (fdCyc !== 147) begin
            $display("[TB] FAIL gray_done_cycle: got %0d want 147", fdCyc);
            mismatched++;
        end
        tick();
        compared++;
        if (bus.frame_count !== 8'd3 || bus.error !== 1'b0) begin
            $display("[TB] FAIL gray_count: got %0d err=%b want 3 err=0", bus.frame_count, bus.error);
            mismatched++;
        end
    endtask

    task automatic test_watchdog();
        int enSnap, cyc, fdCyc;
        memHang = 1'b1;
        startFrame(1'b0);
        cyc = 1;
        while (cyc < 65) begin
            tick();
            cyc++;
        end
        compared++;
        if ({bus.error, bus.busy, bus.cam_capture} !== 3'b011) begin
            $display("[TB] FAIL wd_before_expire: got %b want 011",
                     {bus.error, bus.busy, bus.cam_capture});
            mismatched++;
        end
        tick();
        cyc++;
        compared++;
        if ({bus.error, bus.busy, bus.rwm_enable, bus.cam_capture} !== 4'b1100) begin
            $display("[TB] FAIL wd_error_state: got %b want 1100",
                     {bus.error, bus.busy, bus.rwm_enable, bus.cam_capture});
            mismatched++;
        end
        enSnap = enCount;
        bus.frame_start = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        bus.frame_start = 1'b0;
        compared++;
        if (enCount != enSnap || bus.error !== 1'b1) begin
            $display("[TB] FAIL wd_error_quiet: got enables=%0d err=%b want 0 1",
                     enCount - enSnap, bus.error);
            mismatched++;
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        compared++;
        if ({bus.busy, bus.error} !== 2'b01) begin
            $display("[TB] FAIL wd_abort_exit: got busy/err %b want 01", {bus.busy, bus.error});
            mismatched++;
        end
        memHang = 1'b0;
        startFrame(1'b0);
        cyc = 1;
        compared++;
        if ({bus.error, bus.rwm_enable} !== 2'b01) begin
            $display("[TB] FAIL wd_error_clear: got err/en %b want 01", {bus.error, bus.rwm_enable});
            mismatched++;
        end
        waitFrameDone(cyc, fdCyc);
        tick();
        compared++;
        if (fdCyc !== 28 || bus.frame_count !== 8'd4) begin
            $display("[TB] FAIL wd_recovery_frame: got cyc=%0d cnt=%0d want 28 4", fdCyc, bus.frame_count);
            mismatched++;
        end
    endtask

    task automatic test_abort();
        int startEn, startDone, cyc, idleCyc;
        startEn   = enCount;
        startDone = doneCount;
        idleCyc   = -1;
        startFrame(1'b0);
        cyc = 1;
        while (cyc < 6) begin
            tick();
            cyc++;
        end
        bus.abort = 1'b1;
        tick();
        cyc++;
        bus.abort = 1'b0;
        compared++;
        if ({bus.busy, bus.cam_capture, bus.rwm_enable} !== 3'b100) begin
            $display("[TB] FAIL abort_drain: got %b want 100",
                     {bus.busy, bus.cam_capture, bus.rwm_enable});
            mismatched++;
        end
        tick();
        cyc++;
        bus.frame_start = 1'b1;
        tick();
        cyc++;
        bus.frame_start = 1'b0;
        for (int k = 0; k < 100 && idleCyc < 0; k++) begin
            if (!bus.busy) idleCyc = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        compared++;
        if (idleCyc !== 14) begin
            $display("[TB] FAIL abort_idle_cycle: got %0d want 14", idleCyc);
            mismatched++;
        end
        for (int k = 0; k < 5; k++) tick();
        compared++;
        if (enCount - startEn != 1 || doneCount != startDone || bus.frame_count !== 8'd4 || bus.busy !== 1'b0) begin
            $display("[TB] FAIL abort_no_effect: got en=%0d done=%0d cnt=%0d busy=%b want 1 0 4 0",
                     enCount - startEn, doneCount - startDone, bus.frame_count, bus.busy);
            mismatched++;
        end
    endtask

    task automatic test_wrap();
        int cyc, fdCyc;
        logic allOk;
        allOk = 1'b1;
        for (int n = 0; n < 300 && bus.frame_count != 8'd255; n++) begin
            startFrame(1'b0);
            cyc = 1;
            waitFrameDone(cyc, fdCyc);
            if (fdCyc < 0) allOk = 1'b0;
            tick();
        end
        compared++;
        if (bus.frame_count !== 8'd255 || allOk !== 1'b1) begin
            $display("[TB] FAIL wrap_reach_255: got cnt=%0d ok=%b want 255 1", bus.frame_count, allOk);
            mismatched++;
        end
        startFrame(1'b0);
        cyc = 1;
        waitFrameDone(cyc, fdCyc);
        tick();
        compared++;
        if (bus.frame_count !== 8'd0) begin
            $display("[TB] FAIL wrap_to_zero: got %0d want 0", bus.frame_count);
            mismatched++;
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        startFrame(1'b0);
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            if (bus.gray_start) seen = 1'b1;
        end
        tick();
        tick();
        tick();
        compared++;
        if (bus.busy !== 1'b1 || bus.frame_count !== 8'd0 || seen !== 1'b1) begin
            $display("[TB] FAIL midreset_pre: got busy=%b cnt=%0d seen=%b want 1 0 1",
                     bus.busy, bus.frame_count, seen);
            mismatched++;
        end
        tick();
        startFrame(1'b0);
        cyc_wait_read();
        rst_n = 1'b0;
        #1;
        compared++;
        if (outVec() !== 8'h00 || bus.frame_count !== 8'd0) begin
            $display("[TB] FAIL midreset_outputs: got %b cnt=%0d want 00000000 0", outVec(), bus.frame_count);
            mismatched++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        compared++;
        if (bus.busy !== 1'b0) begin
            $display("[TB] FAIL midreset_release: got busy=%b want 0", bus.busy);
            mismatched++;
        end
    endtask

    task automatic cyc_wait_read();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            if (bus.gray_start) seen = 1'b1;
        end
        tick();
        tick();
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        rst_n           = 1'b0;
        memHang         = 1'b0;
        bus.frame_start = 1'b0;
        bus.clear_en    = 1'b0;
        bus.gray_ready  = 1'b1;
        bus.gray_pause  = 1'b0;
        bus.abort       = 1'b0;

        test_reset();
        test_normal();
        test_clear();
        test_gray_flow();
        test_watchdog();
        test_abort();
        test_wrap();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
